mem_access_unit: RTL and testbench

Load/store memory access unit sitting between the execute stage and the data memory port. It consumes the access-size `mode` produced by `mode_decoder` together with address, store data and a signedness flag. It turns each request into one word-aligned memory transaction with byte strobes. For loads it extracts and extends the addressed byte/half/word into a 32-bit result, so it forms the memory-facing end of the funct3 size encoding.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/lane_align.sv | 50 +++++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store path: one-hot access sizes (also used by
// mode_decoder) and the memory access FSM state encoding.
package mem_pkg;

  localparam logic [2:0] MODE_B = 3'b001;
  localparam logic [2:0] MODE_H = 3'b010;
  localparam logic [2:0] MODE_W = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_t;

  function automatic logic mode_is_legal(input logic [2:0] mode);
    return (mode == MODE_B) || (mode == MODE_H) || (mode == MODE_W);
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering for a 32-bit word port: store strobes and data replication,
// load extraction with sign/zero extension, and the misalignment check.
module lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_mode,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  // Bring the addressed lane down to bit 0 so byte/half extraction is a fixed slice.
  logic [31:0] w_shifted;
  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_wstrb      = 4'b0000;
    o_wdata      = '0;
    o_rdata      = '0;
    o_misaligned = 1'b0;
    case (i_mode)
      MODE_B: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
      end
      MODE_H: begin
        o_wstrb      = 4'b0011 << i_addr_lo;
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
        o_misaligned = i_addr_lo[0];
      end
      MODE_W: begin
        o_wstrb      = 4'b1111;
        o_wdata      = i_wdata;
        o_rdata      = i_rdata;
        o_misaligned = |i_addr_lo;
      end
      default: begin
        o_wstrb = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one CPU request into one word-aligned memory transaction
// and returns the extended load data (or an error) as a single-cycle response.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_mode,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  state_t        r_state;
  logic [2:0]    r_mode;
  logic [1:0]    r_addr_lo;
  logic          r_unsigned;
  logic          r_req_ready;
  logic          r_resp_valid;
  logic          r_resp_err;
  logic [DW-1:0] r_resp_rdata;
  logic          r_mem_valid;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [3:0]    r_mem_wstrb;
  logic [DW-1:0] r_mem_wdata;

  // One aligner serves both directions: live request fields while idle (to decide
  // strobes and errors at acceptance), latched fields afterwards (for load extraction).
  logic [2:0]    w_mode;
  logic [1:0]    w_addr_lo;
  logic [3:0]    w_wstrb;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata_ext;
  logic          w_misaligned;
  logic          w_req_err;

  assign w_mode    = (r_state == ST_IDLE) ? req_mode : r_mode;
  assign w_addr_lo = (r_state == ST_IDLE) ? req_addr[1:0] : r_addr_lo;
  assign w_req_err = !mode_is_legal(req_mode) || w_misaligned;

  lane_align u_lane_align (
    .i_mode       (w_mode),
    .i_addr_lo    (w_addr_lo),
    .i_unsigned   (r_unsigned),
    .i_wdata      (req_wdata),
    .i_rdata      (mem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata_ext),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mode       <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_unsigned   <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= 4'b0000;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_mode      <= req_mode;
            r_addr_lo   <= req_addr[1:0];
            r_unsigned  <= req_unsigned;
            r_req_ready <= 1'b0;
            if (w_req_err) begin
              r_state      <= ST_ERR;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state     <= ST_REQ;
              r_mem_valid <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_addr  <= {req_addr[AW-1:2], 2'b00};
              r_mem_wstrb <= w_wstrb;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            if (r_mem_we) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_rdata_ext;
          end
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        ST_ERR: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_mem_valid  <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_valid  = r_mem_valid;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit: expected memory transactions and
// responses are queued by the stimulus and checked by independent monitors.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_mode;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_exp_t;

  resp_exp_t resp_q[$];
  mem_exp_t  mem_q[$];
  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        acc;

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_mode     (req_mode),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    resp_exp_t e;
    if (!rst && resp_valid) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got rdata 0x%08h err %0b, required no response", resp_rdata, resp_err);
      end else begin
        e = resp_q.pop_front();
        $display("resp  cyc=%0d rdata=0x%08h err=%0b", cyc, resp_rdata, resp_err);
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Memory-side monitor: every accepted memory request must match the oldest expectation.
  always @(negedge clk) begin
    mem_exp_t m;
    if (!rst && mem_valid && mem_ready) begin
      if (mem_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_unexpected: got addr 0x%08h we %0b, required no transaction", mem_addr, mem_we);
      end else begin
        m = mem_q.pop_front();
        $display("mem   cyc=%0d we=%0b addr=0x%08h wstrb=%04b wdata=0x%08h", cyc, mem_we, mem_addr, mem_wstrb, mem_wdata);
        chk("mem_we", 32'(mem_we), 32'(m.we));
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(m.wstrb));
        chk("mem_wdata", mem_wdata, m.wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic [31:0] rdata, input logic err, input int at);
    resp_exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.cyc   = at;
    resp_q.push_back(e);
  endtask

  task automatic expect_mem(input logic we, input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata);
    mem_exp_t m;
    m.we    = we;
    m.addr  = addr;
    m.wstrb = wstrb;
    m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  // Presents one request for exactly one cycle; the unit is idle, so that edge accepts it.
  task automatic issue(input logic we, input logic [2:0] mode, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_mode     = mode;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    tick();
    req_valid    = 1'b0;
    req_wdata    = 32'h0;
  endtask

  task automatic store_seq(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] maddr, input logic [3:0] wstrb, input logic [31:0] mwdata);
    int a;
    a = cyc + 1;
    expect_mem(1'b1, maddr, wstrb, mwdata);
    expect_resp(32'h0, 1'b0, a + 1);
    issue(1'b1, mode, 1'b0, addr, wdata);
    repeat (3) tick();
  endtask

  // Load data is returned so that mem_rvalid is sampled d+1 edges after acceptance.
  task automatic load_seq(input logic [2:0] mode, input logic uns, input logic [31:0] addr,
                          input logic [31:0] word, input int d, input logic [31:0] exp_rdata,
                          input logic [31:0] maddr, input logic [3:0] wstrb);
    int a;
    a = cyc + 1;
    expect_mem(1'b0, maddr, wstrb, 32'h0);
    expect_resp(exp_rdata, 1'b0, a + d + 1);
    issue(1'b0, mode, uns, addr, 32'h0);
    repeat (d) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) tick();
  endtask

  task automatic err_seq(input logic we, input logic [2:0] mode, input logic [31:0] addr);
    int a;
    a = cyc + 1;
    expect_resp(32'h0, 1'b1, a);
    issue(we, mode, 1'b0, addr, 32'hFFFF_FFFF);
    repeat (2) tick();
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_mode     = 3'b000;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    mem_ready    = 1'b1;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'h0;
    repeat (2) tick();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    tick();

    store_seq(MODE_B, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
    load_seq(MODE_H, 1'b0, 32'h0000_2002, 32'h8001_1234, 2, 32'hFFFF_8001, 32'h0000_2000, 4'b1100);
    load_seq(MODE_H, 1'b1, 32'h0000_2002, 32'h8001_1234, 2, 32'h0000_8001, 32'h0000_2000, 4'b1100);
    err_seq(1'b0, MODE_W, 32'h0000_3001);

    // Store word with memory stalled for three cycles: request must hold steady.
    mem_ready = 1'b0;
    acc = cyc + 1;
    expect_mem(1'b1, 32'h0000_4000, 4'b1111, 32'h1234_5678);
    expect_resp(32'h0, 1'b0, acc + 4);
    issue(1'b1, MODE_W, 1'b0, 32'h0000_4000, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_mem_valid", 32'(mem_valid), 32'd1);
      chk("hold_mem_addr", mem_addr, 32'h0000_4000);
      chk("hold_mem_wstrb", 32'(mem_wstrb), 32'(4'b1111));
      chk("hold_mem_wdata", mem_wdata, 32'h1234_5678);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    repeat (3) tick();

    // Reset while waiting for load data: the access is dropped without a response.
    expect_mem(1'b0, 32'h0000_5000, 4'b0010, 32'h0);
    issue(1'b0, MODE_B, 1'b0, 32'h0000_5001, 32'h0);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    load_seq(MODE_B, 1'b1, 32'h0000_5001, 32'h0000_C300, 1, 32'h0000_00C3, 32'h0000_5000, 4'b0010);

    err_seq(1'b0, 3'b011, 32'h0000_6000);
    err_seq(1'b1, MODE_H, 32'h0000_7001);
    store_seq(MODE_H, 32'h0000_7002, 32'h1111_BEEF, 32'h0000_7000, 4'b1100, 32'hBEEF_BEEF);
    load_seq(MODE_B, 1'b0, 32'h0000_8000, 32'h0000_00F0, 1, 32'hFFFF_FFF0, 32'h0000_8000, 4'b0001);
    load_seq(MODE_W, 1'b0, 32'h0000_9004, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 32'h0000_9004, 4'b1111);

    repeat (3) tick();
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
